spi_byte_shifter: RTL

SPI mode-0 master shift engine for one DATA_W-bit word per transaction. It sits directly downstream of the SPI clock/edge divider and consumes that block's single-cycle leading and trailing edge pulses. It generates sclk, cs_n and mosi, samples miso, and returns the received word to the controlling logic through a start/busy/done handshake.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_shift_reg.sv | 35 +++
 rtl/spi_byte_shifter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 byte shifter.
// Bit order is selected by the SPI_LSB_FIRST_EN macro (undefined: MSB first).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } spi_state_e;

  localparam int SPI_DATA_W_DEFAULT = 8;

`ifdef SPI_LSB_FIRST_EN
  localparam bit SPI_LSB_FIRST = 1'b1;
`else
  localparam bit SPI_LSB_FIRST = 1'b0;
`endif

endpackage

// File: rtl/spi_shift_reg.sv
// Parameterised shift register with parallel load, used for both the tx and rx words.
// LSB_FIRST shifts toward bit 0 and enters serial_in at the MSB; otherwise the reverse.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W_DEFAULT,
  parameter bit LSB_FIRST = SPI_LSB_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic              serial_out,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      if (LSB_FIRST) begin
        data <= {serial_in, data[DATA_W-1:1]};
      end else begin
        data <= {data[DATA_W-2:0], serial_in};
      end
    end
  end

  assign serial_out = LSB_FIRST ? data[0] : data[DATA_W-1];

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master shift engine driven by the divider's leading/trailing edge pulses.
// Bit order follows SPI_LSB_FIRST_EN through spi_pkg::SPI_LSB_FIRST.
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              edge_lead,
  input  logic              edge_trail,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  spi_state_e       state;
  logic [CNT_W-1:0] bit_cnt;

  logic              tx_load;
  logic              tx_shift;
  logic              rx_shift;
  logic              tx_next;
  logic              first_bit;
  logic [DATA_W-1:0] tx_preload;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_word_unused;
  logic              rx_out_unused;

  // The first bit goes straight to mosi, so the tx register is loaded one bit ahead:
  // its serial_out is always the bit that the next trailing edge puts on mosi.
  assign first_bit  = SPI_LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
  assign tx_preload = SPI_LSB_FIRST ? (tx_data >> 1) : (tx_data << 1);

  assign tx_load  = (state == IDLE) && start;
  assign rx_shift = (state == SHIFT) && edge_lead;
  assign tx_shift = (state == SHIFT) && !edge_lead && edge_trail && sclk
                    && (bit_cnt != CNT_LAST);

  spi_shift_reg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (SPI_LSB_FIRST)
  ) u_tx_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_load),
    .load_data  (tx_preload),
    .shift_en   (tx_shift),
    .serial_in  (1'b0),
    .serial_out (tx_next),
    .data       (tx_word_unused)
  );

  spi_shift_reg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (SPI_LSB_FIRST)
  ) u_rx_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (1'b0),
    .load_data  ('0),
    .shift_en   (rx_shift),
    .serial_in  (miso),
    .serial_out (rx_out_unused),
    .data       (rx_word)
  );

  // A leading edge always takes priority over a coincident trailing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cs_n    <= 1'b0;
            mosi    <= first_bit;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (edge_trail && !edge_lead) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (edge_lead) begin
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else if (edge_trail && sclk) begin
            sclk <= 1'b0;
            if (bit_cnt == CNT_LAST) begin
              state <= CS_HOLD;
            end else begin
              mosi <= tx_next;
            end
          end
        end
        CS_HOLD: begin
          if (edge_lead) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_word;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
